// File: rtl/platform_field.sv
// platform_field: platform store, scroll/respawn and landing detect.
// Optional macro PLAT_HIT_TOL_EN accepts Dy one line above a platform.
// Ports: Clk, Reset (sync, high), Start, Tick, Scroll, q_Down, Dx, Dy in;
// Ready, Hit, PlatX/PlatY (10 bits per slot, slot k at [10k+9:10k]) out.
module platform_field #(
  parameter int NUM_PLAT = 8,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int PLAT_W   = 64,
  parameter int DOODLE_W = 32
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Tick,
  input  logic                     Scroll,
  input  logic                     q_Down,
  input  logic [9:0]               Dx,
  input  logic [9:0]               Dy,
  output logic                     Ready,
  output logic                     Hit,
  output logic [NUM_PLAT*10-1:0]   PlatX,
  output logic [NUM_PLAT*10-1:0]   PlatY
);

  localparam int IW = (NUM_PLAT > 1) ? $clog2(NUM_PLAT) : 1;
  localparam int STEP = SCREEN_H / NUM_PLAT;
  localparam logic [IW-1:0] LAST = IW'(NUM_PLAT - 1);
  localparam logic [10:0] H11 = 11'(SCREEN_H);
  localparam logic [10:0] DW11 = 11'(DOODLE_W);
  localparam logic [10:0] PW11 = 11'(PLAT_W);

  typedef enum logic [2:0] {
    S_WAIT, S_INIT, S_IDLE, S_SCAN, S_REPORT
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic flag_q, flag_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic ready_q, ready_d;
  logic hit_q, hit_d;
  logic scroll_q, scroll_d;
  logic down_q, down_d;
  logic [9:0] px_q [NUM_PLAT];
  logic [9:0] px_d [NUM_PLAT];
  logic [9:0] py_q [NUM_PLAT];
  logic [9:0] py_d [NUM_PLAT];

  logic [15:0] lfsr_nx;
  logic [9:0] rnd_x;
  logic [9:0] init_y;
  logic [10:0] ny;
  logic [9:0] upd_x;
  logic [9:0] upd_y;
  logic vert;
  logic coll;

  // Fibonacci taps 16,14,13,11 in right-shift form
  assign lfsr_nx = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                    lfsr_q[15:1]};
  assign rnd_x = {1'b0, lfsr_q[8:0]};
  assign init_y = 10'(SCREEN_H - 1 - STEP * int'(idx_q));
  assign ny = {1'b0, py_q[idx_q]} + {10'd0, scroll_q};

  always_comb begin
    upd_x = px_q[idx_q];
    upd_y = ny[9:0];
    if (ny >= H11) begin
      upd_x = rnd_x;
      upd_y = '0;
    end
  end

`ifdef PLAT_HIT_TOL_EN
  assign vert = ({1'b0, Dy} == {1'b0, upd_y}) ||
                ({1'b0, Dy} + 11'd1 == {1'b0, upd_y});
`else
  assign vert = ({1'b0, Dy} == {1'b0, upd_y});
`endif

  assign coll = down_q && vert &&
                ({1'b0, Dx} + DW11 > {1'b0, upd_x}) &&
                ({1'b0, Dx} < {1'b0, upd_x} + PW11);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    flag_d   = flag_q;
    lfsr_d   = lfsr_q;
    ready_d  = ready_q;
    hit_d    = 1'b0;
    scroll_d = scroll_q;
    down_d   = down_q;
    px_d     = px_q;
    py_d     = py_q;
    unique case (state_q)
      S_WAIT: begin
        if (Start) begin
          state_d = S_INIT;
          idx_d   = '0;
        end
      end
      S_INIT: begin
        px_d[idx_q] = rnd_x;
        py_d[idx_q] = init_y;
        lfsr_d      = lfsr_nx;
        idx_d       = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
          idx_d   = '0;
        end
      end
      S_IDLE: begin
        if (Start) begin
          state_d = S_INIT;
          ready_d = 1'b0;
          idx_d   = '0;
        end else if (Tick) begin
          state_d  = S_SCAN;
          ready_d  = 1'b0;
          idx_d    = '0;
          scroll_d = Scroll;
          down_d   = q_Down;
        end
      end
      S_SCAN: begin
        px_d[idx_q] = upd_x;
        py_d[idx_q] = upd_y;
        if (ny >= H11) lfsr_d = lfsr_nx;
        flag_d = flag_q | coll;
        idx_d  = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = S_REPORT;
          hit_d   = flag_q | coll;
          idx_d   = '0;
        end
      end
      S_REPORT: begin
        flag_d  = 1'b0;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_WAIT;
      idx_q    <= '0;
      flag_q   <= 1'b0;
      lfsr_q   <= 16'hACE1;
      ready_q  <= 1'b0;
      hit_q    <= 1'b0;
      scroll_q <= 1'b0;
      down_q   <= 1'b0;
      for (int k = 0; k < NUM_PLAT; k++) begin
        px_q[k] <= '0;
        py_q[k] <= '0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      flag_q   <= flag_d;
      lfsr_q   <= lfsr_d;
      ready_q  <= ready_d;
      hit_q    <= hit_d;
      scroll_q <= scroll_d;
      down_q   <= down_d;
      px_q     <= px_d;
      py_q     <= py_d;
    end
  end

  assign Ready = ready_q;
  assign Hit   = hit_q;

  for (genvar k = 0; k < NUM_PLAT; k++) begin : g_out
    assign PlatX[10*k +: 10] = px_q[k];
    assign PlatY[10*k +: 10] = py_q[k];
  end

endmodule

// File: tb/tb_platform_field.sv
// tb_platform_field: randomized and directed checks of platform_field
// against a slot-list reference model of the platform field.
module tb_platform_field;

  localparam int NP = 8;
`ifdef PLAT_HIT_TOL_EN
  localparam bit TOL = 1'b1;
`else
  localparam bit TOL = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic tick = 1'b0;
  logic scroll = 1'b0;
  logic down = 1'b0;
  logic [9:0] dx = '0;
  logic [9:0] dy = '0;
  logic ready;
  logic hit;
  logic [NP*10-1:0] platx;
  logic [NP*10-1:0] platy;

  platform_field #(
    .NUM_PLAT(NP), .SCREEN_W(640), .SCREEN_H(480),
    .PLAT_W(64), .DOODLE_W(32)
  ) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Tick(tick),
    .Scroll(scroll), .q_Down(down), .Dx(dx), .Dy(dy),
    .Ready(ready), .Hit(hit), .PlatX(platx), .PlatY(platy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int mx [NP];
  int my [NP];
  logic [15:0] lfsr;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] l);
    logic b;
    b = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {b, l[15:1]};
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_init();
    lfsr = 16'hACE1;
    for (int k = 0; k < NP; k++) begin
      mx[k] = int'(lfsr[8:0]);
      my[k] = 479 - k * 60;
      lfsr = lstep(lfsr);
    end
  endtask

  task automatic check_field(input string tag);
    for (int k = 0; k < NP; k++) begin
      check($sformatf("%s_x%0d", tag, k), 32'(platx[10*k +: 10]), mx[k]);
      check($sformatf("%s_y%0d", tag, k), 32'(platy[10*k +: 10]), my[k]);
    end
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_rdy1"}, 32'(ready), 0);
    step(7);
    check({tag, "_rdy8"}, 32'(ready), 0);
    step();
    check({tag, "_rdy9"}, 32'(ready), 1);
    model_init();
    check_field(tag);
  endtask

  task automatic do_tick(input string tag, input int s, input int d,
                         input int x, input int y);
    int ny;
    bit h;
    h = 1'b0;
    for (int k = 0; k < NP; k++) begin
      ny = my[k] + s;
      if (ny >= 480) begin
        my[k] = 0;
        mx[k] = int'(lfsr[8:0]);
        lfsr = lstep(lfsr);
      end else begin
        my[k] = ny;
      end
      if (d != 0 && (y == my[k] || (TOL && y + 1 == my[k])) &&
          x + 32 > mx[k] && x < mx[k] + 64)
        h = 1'b1;
    end
    check({tag, "_pre_rdy"}, 32'(ready), 1);
    tick = 1'b1;
    scroll = s[0];
    down = d[0];
    dx = x[9:0];
    dy = y[9:0];
    step();
    tick = 1'b0;
    scroll = ~s[0];
    down = ~d[0];
    check({tag, "_rdy_lo"}, 32'(ready), 0);
    step(2);
    tick = 1'b1;
    start = 1'b1;
    step();
    tick = 1'b0;
    start = 1'b0;
    step(4);
    check({tag, "_hit_early"}, 32'(hit), 0);
    step();
    check({tag, "_hit"}, 32'(hit), 32'(h));
    step();
    check({tag, "_hit_end"}, 32'(hit), 0);
    check({tag, "_rdy_back"}, 32'(ready), 1);
    check_field(tag);
  endtask

  initial begin
    int x0;
    int j;
    int rx;
    int ry;
    rst = 1'b1;
    step(2);
    check("rst_rdy", 32'(ready), 0);
    check("rst_hit", 32'(hit), 0);
    check("rst_px", 32'(|platx), 0);
    check("rst_py", 32'(|platy), 0);
    rst = 1'b0;
    tick = 1'b1;
    step(2);
    tick = 1'b0;
    check("wait_rdy", 32'(ready), 0);
    check("wait_py", 32'(|platy), 0);

    do_start("init");

    x0 = mx[0];
    do_tick("land", 0, 1, x0 - 20, 479);
    do_tick("land_left_edge", 0, 1, x0 - 32, 479);
    do_tick("land_left_in", 0, 1, x0 - 31, 479);
    do_tick("land_right_in", 0, 1, x0 + 63, 479);
    do_tick("land_right_edge", 0, 1, x0 + 64, 479);
    do_tick("rising", 0, 0, x0 - 20, 479);
    do_tick("dy_off", 0, 1, x0, 478);

    repeat (20) do_tick("scroll", 1, 0, 0, 0);
    check("scroll_y0", 32'(platy[9:0]), 19);
    check("scroll_y1", 32'(platy[19:10]), 439);

    do_tick("tol", 1, 1, mx[5], 199);

    repeat (40) begin
      j = $urandom_range(0, NP - 1);
      rx = mx[j] + $urandom_range(0, 110) - 40;
      if (rx < 0) rx = 0;
      ry = my[j] + $urandom_range(0, 2) - 1;
      if (ry < 0) ry = 0;
      do_tick("rnd", $urandom_range(0, 1), $urandom_range(0, 1), rx, ry);
    end

    dx = 10'(mx[1]);
    dy = 10'(my[1]);
    down = 1'b1;
    scroll = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_rdy", 32'(ready), 0);
    check("mid_rst_hit", 32'(hit), 0);
    check("mid_rst_px", 32'(|platx), 0);
    check("mid_rst_py", 32'(|platy), 0);
    for (int c = 0; c < 10; c++) begin
      step();
      check("post_rst_hit", 32'(hit), 0);
      check("post_rst_rdy", 32'(ready), 0);
    end
    down = 1'b0;
    do_start("reinit");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
